// File: rtl/vram_console.sv
// vram_console: cursor-driven text writer for VRAM port A of the 30x17 text card.
// Define VRAM_CONSOLE_ATTR_ESC_EN to make 0x1B load the next byte as the current attribute.
module vram_console #(
    parameter int         COLS         = 30,
    parameter int         ROWS         = 17,
    parameter logic [7:0] DEFAULT_ATTR = 8'h17,
    parameter logic [7:0] BLANK_CHR    = 8'h20
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [7:0]  chr_i,
    input  logic        chr_valid_i,
    output logic        chr_ready_o,
    output logic        vram_cea_o,
    output logic [10:0] vram_ada_o,
    output logic [7:0]  vram_din_o,
    output logic [4:0]  cursor_row_o,
    output logic [4:0]  cursor_col_o,
    output logic        busy_o
);
    typedef enum logic [2:0] {IDLE, WR_CHR, WR_ATTR, CLR_ROW, CLR_SCR, ESC} state_t;
    localparam logic [4:0] CMAX = 5'(COLS - 1);
    localparam logic [4:0] RMAX = 5'(ROWS - 1);
`ifdef VRAM_CONSOLE_ATTR_ESC_EN
    localparam bit ESC_EN = 1'b1;
`else
    localparam bit ESC_EN = 1'b0;
`endif
    state_t      s, s_n;
    logic [4:0]  row_n, col_n, nl_row;
    logic [7:0]  attr, attr_n, din_n;
    logic [10:0] ada_n;
    logic        cea_n, rdy_n;
    always_comb begin
        s_n    = s;
        row_n  = cursor_row_o;
        col_n  = cursor_col_o;
        attr_n = attr;
        cea_n  = 1'b0;
        ada_n  = vram_ada_o;
        din_n  = vram_din_o;
        nl_row = (cursor_row_o == RMAX) ? 5'd0 : cursor_row_o + 5'd1;
        case (s)
            IDLE: if (chr_valid_i) begin
                if (chr_i == 8'h0D) col_n = 5'd0;
                else if (chr_i == 8'h08) col_n = (cursor_col_o != 5'd0) ? cursor_col_o - 5'd1 : cursor_col_o;
                else if (chr_i == 8'h0A) begin
                    row_n = nl_row;
                    s_n   = CLR_ROW;
                    cea_n = 1'b1;
                    ada_n = {nl_row, 5'd0, 1'b0};
                    din_n = BLANK_CHR;
                end else if (chr_i == 8'h0C) begin
                    s_n   = CLR_SCR;
                    cea_n = 1'b1;
                    ada_n = 11'd0;
                    din_n = BLANK_CHR;
                end else if (ESC_EN && chr_i == 8'h1B) s_n = ESC;
                else begin
                    s_n   = WR_CHR;
                    cea_n = 1'b1;
                    ada_n = {cursor_row_o, cursor_col_o, 1'b0};
                    din_n = chr_i;
                end
            end
            ESC: if (chr_valid_i) begin
                attr_n = chr_i;
                s_n    = IDLE;
            end
            WR_CHR: begin
                s_n   = WR_ATTR;
                cea_n = 1'b1;
                ada_n = {cursor_row_o, cursor_col_o, 1'b1};
                din_n = attr;
            end
            WR_ATTR: if (cursor_col_o != CMAX) begin
                col_n = cursor_col_o + 5'd1;
                s_n   = IDLE;
            end else begin
                col_n = 5'd0;
                row_n = nl_row;
                s_n   = CLR_ROW;
                cea_n = 1'b1;
                ada_n = {nl_row, 5'd0, 1'b0};
                din_n = BLANK_CHR;
            end
            default: begin
                // ada holds the cell just written; a clear with cea low is the post-reset start
                cea_n = 1'b1;
                din_n = BLANK_CHR;
                if (!vram_cea_o) ada_n = 11'd0;
                else if (!vram_ada_o[0]) begin
                    ada_n = {vram_ada_o[10:1], 1'b1};
                    din_n = attr;
                end else if (vram_ada_o[5:1] != CMAX) ada_n = {vram_ada_o[10:6], vram_ada_o[5:1] + 5'd1, 1'b0};
                else if (s == CLR_SCR && vram_ada_o[10:6] != RMAX) ada_n = {vram_ada_o[10:6] + 5'd1, 5'd0, 1'b0};
                else begin
                    cea_n = 1'b0;
                    din_n = vram_din_o;
                    s_n   = IDLE;
                    row_n = (s == CLR_SCR) ? 5'd0 : row_n;
                    col_n = (s == CLR_SCR) ? 5'd0 : col_n;
                end
            end
        endcase
        rdy_n = (s_n == IDLE) || (s_n == ESC);
    end
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            s            <= CLR_SCR;
            attr         <= DEFAULT_ATTR;
            vram_cea_o   <= 1'b0;
            vram_ada_o   <= 11'd0;
            vram_din_o   <= 8'd0;
            chr_ready_o  <= 1'b0;
            busy_o       <= 1'b1;
            cursor_row_o <= 5'd0;
            cursor_col_o <= 5'd0;
        end else begin
            s            <= s_n;
            attr         <= attr_n;
            vram_cea_o   <= cea_n;
            vram_ada_o   <= ada_n;
            vram_din_o   <= din_n;
            chr_ready_o  <= rdy_n;
            busy_o       <= !rdy_n;
            cursor_row_o <= row_n;
            cursor_col_o <= col_n;
        end
    end
endmodule

// File: tb/tb_vram_console.sv
// tb_vram_console: vector table, directed corner sequences and random bytes against a screen model.
module tb_vram_console;
`ifdef VRAM_CONSOLE_ATTR_ESC_EN
    localparam bit ESC_EN = 1'b1;
`else
    localparam bit ESC_EN = 1'b0;
`endif
    logic        clk = 1'b0, rstn = 1'b0, valid = 1'b0;
    logic [7:0]  chr = 8'd0;
    logic        ready, cea, busy;
    logic [10:0] ada;
    logic [7:0]  din;
    logic [4:0]  crow, ccol;
    vram_console dut (
        .clk_i(clk), .rstn_i(rstn), .chr_i(chr), .chr_valid_i(valid), .chr_ready_o(ready),
        .vram_cea_o(cea), .vram_ada_o(ada), .vram_din_o(din),
        .cursor_row_o(crow), .cursor_col_o(ccol), .busy_o(busy)
    );
    always #5 clk = ~clk;
    int passed = 0, total = 0, wr_cnt = 0, oob_cnt = 0;
    logic [7:0] mem [2048];
    always @(posedge clk) if (cea === 1'b1) begin
        mem[ada] = din;
        wr_cnt++;
        if (ada[5:1] >= 5'd30 || ada[10:6] >= 5'd17) oob_cnt++;
    end
    // screen model: plain 2-D arrays and the console rules
    logic [7:0] m_chr [17][30];
    logic [7:0] m_attr [17][30];
    int mr, mc;
    logic [7:0] mattr;
    bit m_esc;
    function automatic void m_clear_row(input int r);
        for (int c = 0; c < 30; c++) begin
            m_chr[r][c] = 8'h20;
            m_attr[r][c] = mattr;
        end
    endfunction
    function automatic void m_newline();
        mr = (mr + 1) % 17;
        m_clear_row(mr);
    endfunction
    function automatic void m_clear_all();
        for (int r = 0; r < 17; r++) m_clear_row(r);
        mr = 0;
        mc = 0;
    endfunction
    function automatic void m_reset();
        mattr = 8'h17;
        m_esc = 1'b0;
        m_clear_all();
    endfunction
    function automatic void m_byte(input logic [7:0] b);
        if (m_esc) begin
            mattr = b;
            m_esc = 1'b0;
        end else if (b == 8'h0D) mc = 0;
        else if (b == 8'h08) mc = (mc > 0) ? mc - 1 : 0;
        else if (b == 8'h0A) m_newline();
        else if (b == 8'h0C) m_clear_all();
        else if (ESC_EN && b == 8'h1B) m_esc = 1'b1;
        else begin
            m_chr[mr][mc] = b;
            m_attr[mr][mc] = mattr;
            if (mc < 29) mc++;
            else begin
                mc = 0;
                m_newline();
            end
        end
    endfunction
    function automatic int cur();
        return {crow, ccol};
    endfunction
    function automatic int addr(input int r, input int c);
        return (r << 6) | (c << 1);
    endfunction
    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask
    task automatic check_screen(input string nm);
        int err = 0;
        for (int r = 0; r < 17; r++)
            for (int c = 0; c < 30; c++)
                if (mem[addr(r, c)] !== m_chr[r][c] || mem[addr(r, c) | 1] !== m_attr[r][c]) err++;
        check(nm, err, 0);
    endtask
    task automatic wait_ready(input int w0, output int cyc, output int wrs);
        cyc = 0;
        while (ready !== 1'b1 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (ready !== 1'b1) check("ready_timeout", 0, 1);
        wrs = wr_cnt - w0;
    endtask
    task automatic send(input logic [7:0] b, input bit wait_done, output int cyc, output int wrs);
        int t = 0;
        int w0;
        chr = b;
        valid = 1'b1;
        while (ready !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (ready !== 1'b1) check("accept_timeout", 0, 1);
        w0 = wr_cnt;
        @(posedge clk);
        #1;
        valid = 1'b0;
        m_byte(b);
        cyc = 0;
        wrs = 0;
        if (wait_done) begin
            wait_ready(w0, cyc, wrs);
            cyc++;
        end
    endtask
    typedef struct {
        logic [7:0] b;
        int row, col, cyc, wrs;
    } vec_t;
    vec_t v[8];
    initial begin
        int cyc, wrs, w0, err, r0, c0;
        logic [7:0] b;
        for (int i = 0; i < 2048; i++) mem[i] = 8'hFF;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_cea", cea, 0);
        check("rst_ada", ada, 0);
        check("rst_din", din, 0);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 1);
        check("rst_cursor", cur(), 0);
        check("rst_no_write", wr_cnt, 0);
        @(negedge clk);
        rstn = 1'b1;
        wait_ready(wr_cnt, cyc, wrs);
        check("init_clr_cycles", cyc, 1021);
        check("init_clr_writes", wrs, 1020);
        check("init_cursor", cur(), 0);
        check("init_busy", busy, 0);
        check_screen("init_screen");
        // 'A' at (0,0): exact per-cycle write pattern
        @(negedge clk);
        chr = 8'h41;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        check("a_chr_cea", cea, 1);
        check("a_chr_ada", ada, 11'h000);
        check("a_chr_din", din, 8'h41);
        @(posedge clk);
        #1;
        check("a_attr_ada", ada, 11'h001);
        check("a_attr_din", din, 8'h17);
        @(posedge clk);
        #1;
        check("a_done_ready", ready, 1);
        check("a_done_cea", cea, 0);
        check("a_cursor", cur(), 1);
        m_byte(8'h41);
        v = '{'{8'h08, 0, 0, 1, 0}, '{8'h08, 0, 0, 1, 0}, '{8'h42, 0, 1, 3, 2}, '{8'h0D, 0, 0, 1, 0},
              '{8'h0A, 1, 0, 61, 60}, '{8'h0A, 2, 0, 61, 60}, '{8'h43, 2, 1, 3, 2}, '{8'h0C, 0, 0, 1021, 1020}};
        for (int i = 0; i < 8; i++) begin
            send(v[i].b, 1'b1, cyc, wrs);
            check($sformatf("vec%0d_cursor", i), cur(), (v[i].row << 5) | v[i].col);
            check($sformatf("vec%0d_cycles", i), cyc, v[i].cyc);
            check($sformatf("vec%0d_writes", i), wrs, v[i].wrs);
        end
        check_screen("table_screen");
        // column-29 wrap into a row-1 clear
        for (int i = 0; i < 29; i++) send(8'h61, 1'b1, cyc, wrs);
        check("col29_cursor", cur(), 29);
        @(negedge clk);
        chr = 8'h5A;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        check("z_chr_ada", ada, 11'h03A);
        check("z_chr_din", din, 8'h5A);
        @(posedge clk);
        #1;
        check("z_attr_ada", ada, 11'h03B);
        @(posedge clk);
        #1;
        check("z_cursor", cur(), 32);
        check("z_clr_first", {cea, ada, din}, {1'b1, 11'h040, 8'h20});
        err = 0;
        for (int k = 1; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (cea !== 1'b1 || ada !== 11'(11'h040 + k)) err++;
        end
        check("z_clr_seq", err, 0);
        @(posedge clk);
        #1;
        check("z_clr_done", {ready, cea}, 2'b10);
        m_byte(8'h5A);
        // bottom-row LF wraps to row 0 and blanks it
        for (int i = 0; i < 15; i++) send(8'h0A, 1'b1, cyc, wrs);
        for (int i = 0; i < 5; i++) send(8'h68, 1'b1, cyc, wrs);
        check("r16_cursor", cur(), (16 << 5) | 5);
        send(8'h0A, 1'b1, cyc, wrs);
        check("lf_wrap_cursor", cur(), 5);
        check("lf_wrap_writes", wrs, 60);
        check_screen("lf_wrap_screen");
        send(8'h0D, 1'b1, cyc, wrs);
        check("cr_cursor", cur(), 0);
        send(8'h08, 1'b1, cyc, wrs);
        check("bs0_cursor", cur(), 0);
        check("bs0_writes", wrs, 0);
        r0 = mr;
        c0 = mc;
        if (ESC_EN) begin
            send(8'h1B, 1'b1, cyc, wrs);
            check("esc_writes", wrs, 0);
            send(8'h4E, 1'b1, cyc, wrs);
            check("esc_arg_writes", wrs, 0);
            send(8'h78, 1'b1, cyc, wrs);
            check("esc_attr", mem[addr(r0, c0) | 1], 8'h4E);
        end else begin
            send(8'h1B, 1'b1, cyc, wrs);
            check("glyph1b_writes", wrs, 2);
            check("glyph1b_chr", mem[addr(r0, c0)], 8'h1B);
        end
        // random bytes, sometimes offered while the console is still busy
        for (int i = 0; i < 400; i++) begin
            int p = $urandom_range(0, 99);
            bit wd = 1'($urandom_range(0, 1));
            b = (p < 2) ? 8'h0C : (p < 10) ? 8'h0A : (p < 16) ? 8'h0D : (p < 24) ? 8'h08 :
                (p < 30) ? 8'h1B : 8'($urandom_range(0, 255));
            send(b, wd, cyc, wrs);
            if (wd) check("rand_cursor", cur(), (mr << 5) | mc);
        end
        wait_ready(wr_cnt, cyc, wrs);
        check_screen("rand_screen");
        // reset in the middle of a row clear
        send(8'h0A, 1'b0, cyc, wrs);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_cea", cea, 0);
        check("midrst_cursor", cur(), 0);
        check("midrst_busy_ready", {busy, ready}, 2'b10);
        @(negedge clk);
        rstn = 1'b1;
        m_reset();
        wait_ready(wr_cnt, cyc, wrs);
        check("midrst_writes", wrs, 1020);
        check_screen("midrst_screen");
        check("oob_writes", oob_cnt, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
